button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Upstream input stage for the seven-segment animation controller. It conditions N_BTN raw push-button inputs (next/prev animation, faster/slower) into clean per-button events. Per channel: synchroniser, debounce FSM, single-cycle press/release pulses and optional auto-repeat. Outputs feed the animation-select and speed-step logic, which act once per btn_press pulse instead of on a held level.

Parameters:
N_BTN, 4, number of independent button channels
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 512, consecutive stable samples required to accept a level change (>=2)
REPEAT_DELAY, 5_000_000, cycles from the initial press pulse to the first auto-repeat pulse (>=1)
REPEAT_RATE, 2_000_000, cycles between successive auto-repeat pulses (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
btn_in  input  N_BTN  raw asynchronous button levels, active-high
btn_level  output  N_BTN  debounced level per button
btn_press  output  N_BTN  one-cycle pulse on accepted press and on each auto-repeat
btn_release  output  N_BTN  one-cycle pulse on accepted release

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk. All flops update on posedge clk.
- Reset: sync flops, btn_level, btn_press and btn_release all go to 0. Every state is IDLE and every counter is 0. Reset wins over all other activity, including mid-debounce and mid-repeat.
- Channels are fully independent, with no priority. Simultaneous activity on several channels gives pulses in the same cycle.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops and produces s[i]. All FSM decisions use s[i] only.
- Per-channel FSM: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
  - IDLE: btn_level=0. When s=1, go to PRESS_WAIT with deb_cnt=1.
  - PRESS_WAIT: when s=1, deb_cnt increments. If s=1 and deb_cnt==DEBOUNCE_CYCLES-1, go to HELD, btn_level<=1, btn_press<=1 for one cycle, rep_cnt<=0. Any s=0 sample returns to IDLE, deb_cnt<=0, with no output.
  - HELD: rep_cnt increments every cycle. When rep_cnt==REPEAT_DELAY-1, pulse btn_press, rep_cnt<=0, go to REPEAT.
  - REPEAT: rep_cnt increments every cycle. When rep_cnt==REPEAT_RATE-1, pulse btn_press and rep_cnt<=0.
  - HELD/REPEAT with s=0: go to RELEASE_WAIT, deb_cnt=1, remembering the return state. rep_cnt freezes and btn_level stays 1.
  - RELEASE_WAIT: when s=0, deb_cnt increments. If s=0 and deb_cnt==DEBOUNCE_CYCLES-1, go to IDLE, btn_level<=0, btn_release pulse. Any s=1 sample returns to the remembered state, deb_cnt<=0, and rep_cnt resumes from its frozen value.
- Latency: btn_in first sampled high at edge 0 and held stable gives btn_press/btn_level high after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. The same latency applies to a release.
- A press pulse and a release pulse never occur in the same cycle on one channel.
- Counter widths: $clog2 of the largest compared value. Counters must never wrap.
- A btn_in asserted through reset is re-debounced from reset release and produces a fresh press pulse.

Optional Feature:
BUTTON_AUTO_REPEAT_EN
- Defined: HELD/REPEAT auto-repeat as specified above.
- Undefined: no REPEAT state and no rep_cnt logic. HELD idles until release, so exactly one btn_press per debounced press. REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=16, macro defined unless stated. Cycle numbers count edges from the first sample of the stimulus.
- Clean press: btn_in[0]=1 from edge 0 to edge 29, then 0 -> btn_press[0] single pulse after edge 9; btn_level[0]=1 from edge 9; btn_release[0] pulse after edge 39 and btn_level[0]=0 from then; other channels stay silent.
- Bounce: btn_in[1] toggles 5 high / 5 low three times, then stays 0 -> no btn_press, btn_release or btn_level activity on channel 1.
- Auto-repeat: btn_in[2]=1 for edges 0..119 -> btn_press[2] pulses after edges 9, 49, 65, 81, 97, 113; btn_release[2] after edge 129; no pulse during RELEASE_WAIT.
- Release glitch: while held, btn_in[2]=0 for 4 cycles -> no btn_release, btn_level stays 1, repeat schedule shifts by exactly 4 cycles (frozen rep_cnt).
- Reset mid-hold: reset for 1 cycle during REPEAT with btn_in[3] still 1 -> all outputs 0 next cycle; fresh btn_press[3] 10 edges after reset release.
- Macro undefined plus simultaneous press: btn_in[0] and btn_in[3] high for edges 0..119 -> exactly one btn_press on each, both after edge 9 in the same cycle; both releases after edge 129.

Source files
------------

// File: rtl/button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions N_BTN raw push-button inputs into clean per-button
//               events for the animation controller. Each channel has its own
//               synchroniser, debounce FSM, registered one-cycle press/release
//               pulses and an optional auto-repeat generator.
//
// Ports       : clk          - clock, all flops update on the rising edge
//               reset        - synchronous, active-high reset
//               btn_in       - [N_BTN] raw asynchronous button levels (high = pressed)
//               btn_level    - [N_BTN] debounced level per button
//               btn_press    - [N_BTN] one-cycle pulse on accepted press and
//                              on every auto-repeat tick
//               btn_release  - [N_BTN] one-cycle pulse on accepted release
//
// Build macro : BUTTON_AUTO_REPEAT_EN
//               defined   -> HELD/REPEAT auto-repeat using REPEAT_DELAY and
//                            REPEAT_RATE
//               undefined -> one press pulse per debounced press, no repeat
//                            state or repeat counter
//
// Revision    : 1.0 - initial release
// ============================================================================

module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_RATE     = 2_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // ------------------------------------------------------------------------
    // Debounce counter: counts 1 .. DEBOUNCE_CYCLES-1 and never beyond, since
    // reaching the last value always leaves the waiting state.
    // ------------------------------------------------------------------------
    localparam int                 c_DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);

    // Per-channel state encoding
    localparam logic [2:0] c_IDLE         = 3'd0;
    localparam logic [2:0] c_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] c_HELD         = 3'd2;
    localparam logic [2:0] c_RELEASE_WAIT = 3'd4;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [2:0] c_REPEAT = 3'd3;

    // Repeat counter is shared by the initial delay and the repeat period,
    // so it is sized for the larger of the two.
    localparam int                 c_REP_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int                 c_REP_W      = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
    localparam logic [c_REP_W-1:0] c_DELAY_LAST = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_RATE_LAST  = c_REP_W'(REPEAT_RATE - 1);
`endif

    localparam bit c_PARAMS_OK = (N_BTN >= 1) && (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 2) &&
                                 (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);

    if (!c_PARAMS_OK) begin : g_param_check
        $error("button_conditioner: parameter out of range");
    end

    // ------------------------------------------------------------------------
    // Independent channels
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;

        logic [2:0]             r_state;
        logic [2:0]             w_state_nxt;
        logic [c_DEB_W-1:0]     r_deb_cnt;
        logic [c_DEB_W-1:0]     w_deb_cnt_nxt;
        logic                   r_level;
        logic                   w_level_nxt;
        logic                   r_press;
        logic                   w_press_nxt;
        logic                   r_release;
        logic                   w_release_nxt;

        // Outcome of one "button still held" cycle, shared by HELD, REPEAT
        // and the return path out of RELEASE_WAIT.
        logic [2:0]             w_hold_state;
        logic                   w_hold_press;

        // --------------------------------------------------------------------
        // Synchroniser: shift btn_in through SYNC_STAGES flops; the FSM only
        // ever looks at the last stage.
        // --------------------------------------------------------------------
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[gi]};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];

`ifdef BUTTON_AUTO_REPEAT_EN
        logic [c_REP_W-1:0]     r_rep_cnt;
        logic [c_REP_W-1:0]     w_rep_cnt_nxt;
        logic                   r_ret_repeat;
        logic                   w_ret_repeat_nxt;
        logic                   w_rep_in_repeat;
        logic                   w_rep_hit;
        logic [c_REP_W-1:0]     w_hold_rep;

        // While in RELEASE_WAIT the frozen counter still belongs to the
        // schedule of the state we will return to.
        assign w_rep_in_repeat = (r_state == c_REPEAT) ||
                                 ((r_state == c_RELEASE_WAIT) && r_ret_repeat);
        assign w_rep_hit       = (r_rep_cnt == (w_rep_in_repeat ? c_RATE_LAST : c_DELAY_LAST));

        always_comb begin
            w_hold_state = w_rep_in_repeat ? c_REPEAT : c_HELD;
            w_hold_rep   = r_rep_cnt + 1'b1;
            w_hold_press = 1'b0;
            if (w_rep_hit) begin
                w_hold_state = c_REPEAT;
                w_hold_rep   = '0;
                w_hold_press = 1'b1;
            end
        end
`else
        assign w_hold_state = c_HELD;
        assign w_hold_press = 1'b0;
`endif

        // --------------------------------------------------------------------
        // Next-state / output logic
        // --------------------------------------------------------------------
        always_comb begin
            w_state_nxt   = r_state;
            w_deb_cnt_nxt = r_deb_cnt;
            w_level_nxt   = r_level;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            w_rep_cnt_nxt    = r_rep_cnt;
            w_ret_repeat_nxt = r_ret_repeat;
`endif
            case (r_state)
                c_IDLE: begin
                    if (w_s) begin
                        w_state_nxt   = c_PRESS_WAIT;
                        w_deb_cnt_nxt = c_DEB_ONE;
                    end
                end

                c_PRESS_WAIT: begin
                    if (!w_s) begin
                        w_state_nxt   = c_IDLE;
                        w_deb_cnt_nxt = '0;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        w_state_nxt   = c_HELD;
                        w_deb_cnt_nxt = '0;
                        w_level_nxt   = 1'b1;
                        w_press_nxt   = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                        w_rep_cnt_nxt    = '0;
                        w_ret_repeat_nxt = 1'b0;
`endif
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                    end
                end

                c_HELD
`ifdef BUTTON_AUTO_REPEAT_EN
                , c_REPEAT
`endif
                : begin
                    if (w_s) begin
                        w_state_nxt = w_hold_state;
                        w_press_nxt = w_hold_press;
`ifdef BUTTON_AUTO_REPEAT_EN
                        w_rep_cnt_nxt = w_hold_rep;
`endif
                    end else begin
                        // First low sample: start release debounce, counter freezes
                        w_state_nxt   = c_RELEASE_WAIT;
                        w_deb_cnt_nxt = c_DEB_ONE;
`ifdef BUTTON_AUTO_REPEAT_EN
                        w_ret_repeat_nxt = (r_state == c_REPEAT);
`endif
                    end
                end

                c_RELEASE_WAIT: begin
                    if (w_s) begin
                        // Glitch rejected: this high sample counts as a held
                        // cycle, so the repeat schedule shifts only by the
                        // number of low samples seen.
                        w_state_nxt   = w_hold_state;
                        w_press_nxt   = w_hold_press;
                        w_deb_cnt_nxt = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                        w_rep_cnt_nxt = w_hold_rep;
`endif
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        w_state_nxt   = c_IDLE;
                        w_deb_cnt_nxt = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                        w_rep_cnt_nxt    = '0;
                        w_ret_repeat_nxt = 1'b0;
`endif
                    end else begin
                        w_deb_cnt_nxt = r_deb_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt   = c_IDLE;
                    w_deb_cnt_nxt = '0;
                    w_level_nxt   = 1'b0;
                end
            endcase
        end

        // --------------------------------------------------------------------
        // State, counters and registered outputs
        // --------------------------------------------------------------------
        always_ff @(posedge clk) begin
            if (reset) begin
                r_state   <= c_IDLE;
                r_deb_cnt <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                r_rep_cnt    <= '0;
                r_ret_repeat <= 1'b0;
`endif
            end else begin
                r_state   <= w_state_nxt;
                r_deb_cnt <= w_deb_cnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
`ifdef BUTTON_AUTO_REPEAT_EN
                r_rep_cnt    <= w_rep_cnt_nxt;
                r_ret_repeat <= w_ret_repeat_nxt;
`endif
            end
        end

        assign btn_level[gi]   = r_level;
        assign btn_press[gi]   = r_press;
        assign btn_release[gi] = r_release;
    end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner with
//               SYNC_STAGES=2, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40,
//               REPEAT_RATE=16. A run-length based reference model is checked
//               every cycle; a segment table checks pulse counts and levels;
//               hand-written sequences cover reset during a hold.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_button_conditioner;

    localparam int c_N   = 4;
    localparam int c_DEB = 8;
    localparam int c_RD  = 40;
    localparam int c_RR  = 16;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int c_AR = 1;
`else
    localparam int c_AR = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [c_N-1:0]   btn_in = '0;
    logic [c_N-1:0]   btn_level;
    logic [c_N-1:0]   btn_press;
    logic [c_N-1:0]   btn_release;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (c_N),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(c_DEB),
        .REPEAT_DELAY   (c_RD),
        .REPEAT_RATE    (c_RR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------------------
    // Reference model: the input seen by the decision logic is btn_in two
    // edges old. A level change is accepted after c_DEB consecutive samples of
    // the new value. While accepted high, every high sample advances a held
    // count; repeats fire at held == RD, RD+RR, RD+2RR, ...
    // ------------------------------------------------------------------------
    logic [c_N-1:0] m_h0, m_h1, m_level, m_press, m_release;
    int             m_run  [c_N];
    int             m_held [c_N];
    int             press_cnt [c_N];
    int             rel_cnt   [c_N];

    task automatic model_edge(input logic rst, input logic [c_N-1:0] din);
        logic s;
        if (rst) begin
            m_h0 = '0; m_h1 = '0; m_level = '0; m_press = '0; m_release = '0;
            for (int i = 0; i < c_N; i++) begin
                m_run[i]  = 0;
                m_held[i] = 0;
            end
        end else begin
            for (int i = 0; i < c_N; i++) begin
                s = m_h1[i];
                m_press[i]   = 1'b0;
                m_release[i] = 1'b0;
                if (!m_level[i]) begin
                    m_run[i] = s ? m_run[i] + 1 : 0;
                    if (m_run[i] == c_DEB) begin
                        m_level[i] = 1'b1; m_press[i] = 1'b1; m_run[i] = 0; m_held[i] = 0;
                    end
                end else if (!s) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == c_DEB) begin
                        m_level[i] = 1'b0; m_release[i] = 1'b1; m_run[i] = 0;
                    end
                end else begin
                    m_run[i]  = 0;
                    m_held[i] = m_held[i] + 1;
                    if (c_AR == 1) begin
                        if (m_held[i] == c_RD || (m_held[i] > c_RD && ((m_held[i] - c_RD) % c_RR) == 0))
                            m_press[i] = 1'b1;
                    end
                end
            end
            m_h1 = m_h0;
            m_h0 = din;
        end
    endtask

    // One clock: drive, advance model on the edge, compare 1 time unit later.
    task automatic step(input logic [c_N-1:0] din, input logic rst);
        btn_in = din;
        reset  = rst;
        @(posedge clk);
        model_edge(rst, din);
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
            failures++;
            $display("FAIL model t=%0t got level=%b press=%b release=%b exp level=%b press=%b release=%b",
                     $time, btn_level, btn_press, btn_release, m_level, m_press, m_release);
        end
        for (int i = 0; i < c_N; i++) begin
            press_cnt[i] += int'(btn_press[i]);
            rel_cnt[i]   += int'(btn_release[i]);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < c_N; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
    endtask

    // ------------------------------------------------------------------------
    // Segment table: hold btn for cycles edges, then compare per-channel press
    // and release counts (8 bits per channel, ch0 in the low byte) and final
    // levels.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [c_N-1:0] btn;
        int             cycles;
        logic [31:0]    exp_press;
        logic [31:0]    exp_rel;
        logic [c_N-1:0] exp_level;
    } vec_t;

    localparam int c_NV = 18;
    vec_t vecs [c_NV];

    function automatic vec_t mk(input logic [c_N-1:0] b, input int c,
                                input logic [31:0] p, input logic [31:0] r,
                                input logic [c_N-1:0] l);
        vec_t v;
        v.btn = b; v.cycles = c; v.exp_press = p; v.exp_rel = r; v.exp_level = l;
        return v;
    endfunction

    int          first;
    int          remain [c_N];
    logic [c_N-1:0] cur;
    logic        rrst;

    initial begin
        // idle
        vecs[0]  = mk(4'b0000, 10, 32'h0, 32'h0, 4'b0000);
        // clean press / release on ch0
        vecs[1]  = mk(4'b0001, 30, 32'h00000001, 32'h0, 4'b0001);
        vecs[2]  = mk(4'b0000, 20, 32'h0, 32'h00000001, 4'b0000);
        // bounce on ch1: 5 high / 5 low three times
        vecs[3]  = mk(4'b0010, 5, 32'h0, 32'h0, 4'b0000);
        vecs[4]  = mk(4'b0000, 5, 32'h0, 32'h0, 4'b0000);
        vecs[5]  = mk(4'b0010, 5, 32'h0, 32'h0, 4'b0000);
        vecs[6]  = mk(4'b0000, 5, 32'h0, 32'h0, 4'b0000);
        vecs[7]  = mk(4'b0010, 5, 32'h0, 32'h0, 4'b0000);
        vecs[8]  = mk(4'b0000, 5, 32'h0, 32'h0, 4'b0000);
        vecs[9]  = mk(4'b0000, 20, 32'h0, 32'h0, 4'b0000);
        // auto-repeat on ch2: pulses after 9,49,65,81,97,113
        vecs[10] = mk(4'b0100, 120, (c_AR == 1) ? 32'h00060000 : 32'h00010000, 32'h0, 4'b0100);
        vecs[11] = mk(4'b0000, 20, 32'h0, 32'h00010000, 4'b0000);
        // release glitch on ch2: 4 low cycles shift 65,81,97 to 69,85,101
        vecs[12] = mk(4'b0100, 60, (c_AR == 1) ? 32'h00020000 : 32'h00010000, 32'h0, 4'b0100);
        vecs[13] = mk(4'b0000, 4, 32'h0, 32'h0, 4'b0100);
        vecs[14] = mk(4'b0100, 40, (c_AR == 1) ? 32'h00030000 : 32'h0, 32'h0, 4'b0100);
        vecs[15] = mk(4'b0000, 20, 32'h0, 32'h00010000, 4'b0000);
        // simultaneous ch0 + ch3
        vecs[16] = mk(4'b1001, 120, (c_AR == 1) ? 32'h06000006 : 32'h01000001, 32'h0, 4'b1001);
        vecs[17] = mk(4'b0000, 20, 32'h0, 32'h01000001, 4'b0000);

        // ---------------- reset state ----------------
        for (int c = 0; c < 3; c++) step(4'b0000, 1'b1);
        checks++;
        if ({btn_level, btn_press, btn_release} !== 12'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0", {btn_level, btn_press, btn_release});
        end

        // ---------------- table ----------------
        for (int r = 0; r < c_NV; r++) begin
            clear_counts();
            for (int c = 0; c < vecs[r].cycles; c++) step(vecs[r].btn, 1'b0);
            for (int i = 0; i < c_N; i++) begin
                checks++;
                if (press_cnt[i] != int'(vecs[r].exp_press[8*i +: 8])) begin
                    failures++;
                    $display("FAIL row%0d press_count ch%0d got=%0d exp=%0d",
                             r, i, press_cnt[i], vecs[r].exp_press[8*i +: 8]);
                end
                checks++;
                if (rel_cnt[i] != int'(vecs[r].exp_rel[8*i +: 8])) begin
                    failures++;
                    $display("FAIL row%0d release_count ch%0d got=%0d exp=%0d",
                             r, i, rel_cnt[i], vecs[r].exp_rel[8*i +: 8]);
                end
            end
            checks++;
            if (btn_level !== vecs[r].exp_level) begin
                failures++;
                $display("FAIL row%0d level got=%b exp=%b", r, btn_level, vecs[r].exp_level);
            end
        end

        // ---------------- reset while ch3 is held ----------------
        for (int c = 0; c < 60; c++) step(4'b1000, 1'b0);
        step(4'b1000, 1'b1);
        checks++;
        if ({btn_level, btn_press, btn_release} !== 12'b0) begin
            failures++;
            $display("FAIL reset_mid_hold got=%b exp=0", {btn_level, btn_press, btn_release});
        end
        first = 0;
        for (int n = 1; n <= 30; n++) begin
            step(4'b1000, 1'b0);
            if (btn_press[3] && first == 0) first = n;
        end
        checks++;
        if (first != 10) begin
            failures++;
            $display("FAIL reset_repress_latency got=%0d exp=10 (0 = no press within 30 cycles)", first);
        end
        clear_counts();
        for (int c = 0; c < 20; c++) step(4'b0000, 1'b0);
        checks++;
        if (rel_cnt[3] != 1) begin
            failures++;
            $display("FAIL reset_release got=%0d exp=1", rel_cnt[3]);
        end

        // ---------------- randomized runs against the model ----------------
        cur = '0;
        for (int i = 0; i < c_N; i++) remain[i] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < c_N; i++) begin
                remain[i] = remain[i] - 1;
                if (remain[i] <= 0) begin
                    cur[i] = ~cur[i];
                    if ($urandom_range(0, 1) != 0)
                        remain[i] = int'($urandom_range(1, 9));
                    else
                        remain[i] = int'($urandom_range(8, 140));
                end
            end
            rrst = ($urandom_range(0, 599) == 0);
            step(cur, rrst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
